prog_loader: RTL and testbench

Boot-time program loader for the J1 program memory: writer-side counterpart of the synchronous program ROM/RAM read port. It consumes a byte stream (typically from a UART receiver), assembles big-endian 16-bit words, and drives the memory's write port sequentially from address 0. It holds the CPU in reset until a complete image has been written.

---
 rtl/prog_loader.sv | 156 +++++++++++++++
 tb/tb_prog_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot-time program loader: assembles big-endian 16-bit words from a byte stream
// and writes them to program memory from address 0. Optional LOADER_CHECKSUM_EN adds an XOR checksum byte.
module prog_loader #(
  parameter int size       = 'h1000,
  parameter int addr_width = $clog2(size),
  parameter int data_width = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [addr_width-1:0] wr_address,
  output logic [data_width-1:0] wr_data,
  output logic                  wr_en,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  localparam logic [7:0]  MAGIC  = 8'hA5;
  localparam logic [16:0] SIZE_N = 17'(size);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR} state_t;
  localparam state_t FINAL_ST = CHECK;
`else
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, DONE, ERROR} state_t;
  localparam state_t FINAL_ST = DONE;
`endif

  state_t                state, state_n;
  logic [15:0]           len, len_n, len_rx;
  logic [15:0]           cnt, cnt_n, cnt_inc;
  logic [7:0]            hi, hi_n;
  logic [addr_width-1:0] addr, addr_n;
  logic [addr_width-1:0] wr_address_n;
  logic [data_width-1:0] wr_data_n;
  logic                  wr_en_n;
  logic                  start;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum, csum_n;
  logic                  acc;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      len        <= '0;
      cnt        <= '0;
      hi         <= '0;
      addr       <= '0;
      wr_address <= '0;
      wr_data    <= '0;
      wr_en      <= 1'b0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      state      <= state_n;
      len        <= len_n;
      cnt        <= cnt_n;
      hi         <= hi_n;
      addr       <= addr_n;
      wr_address <= wr_address_n;
      wr_data    <= wr_data_n;
      wr_en      <= wr_en_n;
      // Status flags are registered images of the next state.
      cpu_reset  <= (state_n != DONE);
      done       <= (state_n == DONE);
      error      <= (state_n == ERROR);
`ifdef LOADER_CHECKSUM_EN
      csum       <= csum_n;
`endif
    end
  end

  always_comb begin
    state_n      = state;
    len_n        = len;
    cnt_n        = cnt;
    hi_n         = hi;
    addr_n       = addr;
    wr_address_n = wr_address;
    wr_data_n    = wr_data;
    wr_en_n      = 1'b0;
    start        = 1'b0;
    len_rx       = {len[15:8], rx_data};
    cnt_inc      = cnt + 16'd1;
`ifdef LOADER_CHECKSUM_EN
    csum_n       = csum;
    acc          = 1'b0;
`endif

    if (rx_valid) begin
      case (state)
        IDLE: start = (rx_data == MAGIC);
        LEN_HI: begin
          len_n   = {rx_data, 8'h00};
          state_n = LEN_LO;
`ifdef LOADER_CHECKSUM_EN
          acc     = 1'b1;
`endif
        end
        LEN_LO: begin
          len_n = len_rx;
          if ({1'b0, len_rx} > SIZE_N) state_n = ERROR;
          else if (len_rx == 16'd0)    state_n = FINAL_ST;
          else                         state_n = DATA_HI;
`ifdef LOADER_CHECKSUM_EN
          acc   = 1'b1;
`endif
        end
        DATA_HI: begin
          hi_n    = rx_data;
          state_n = DATA_LO;
`ifdef LOADER_CHECKSUM_EN
          acc     = 1'b1;
`endif
        end
        DATA_LO: begin
          wr_en_n      = 1'b1;
          wr_address_n = addr;
          wr_data_n    = data_width'({hi, rx_data});
          addr_n       = addr + addr_width'(1);
          cnt_n        = cnt_inc;
          state_n      = (cnt_inc == len) ? FINAL_ST : DATA_HI;
`ifdef LOADER_CHECKSUM_EN
          acc          = 1'b1;
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: state_n = (rx_data == csum) ? DONE : ERROR;
`endif
        ERROR:   start = (rx_data == MAGIC);
        default: ;
      endcase
    end

`ifdef LOADER_CHECKSUM_EN
    if (acc) csum_n = csum ^ rx_data;
`endif

    if (start) begin
      state_n = LEN_HI;
      addr_n  = '0;
      cnt_n   = '0;
`ifdef LOADER_CHECKSUM_EN
      csum_n  = '0;
`endif
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader; frames get a checksum byte appended
// when LOADER_CHECKSUM_EN is defined.
module tb_prog_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [11:0] wr_address;
  logic [15:0] wr_data;
  logic        wr_en;
  logic        cpu_reset;
  logic        done;
  logic        error;

  prog_loader #(.size('h1000)) dut (
    .clock      (clock),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .wr_address (wr_address),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [11:0] wa_q[$];
  logic [15:0] wd_q[$];
  int          wc_q[$];
  logic [7:0]  fq[$];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (wr_en === 1'b1) begin
      wa_q.push_back(wr_address);
      wd_q.push_back(wr_data);
      wc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset    = 1'b1;
    rx_valid = 1'b0;
    @(negedge clock);
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clock);
    rx_valid = 1'b0;
    #1;
  endtask

  // Sends fq[first..] one byte per cycle with rx_valid held high.
  task automatic stream(input int first);
    for (int i = first; i < fq.size(); i++) begin
      @(negedge clock);
      rx_data  = fq[i];
      rx_valid = 1'b1;
    end
    @(negedge clock);
    rx_valid = 1'b0;
    #1;
  endtask

  task automatic send_gapped(input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(fq[i]);
  endtask

  // Appends the XOR of every byte after the magic when the checksum build is active.
  task automatic seal();
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    for (int i = 1; i < fq.size(); i++) x ^= fq[i];
    fq.push_back(x);
`endif
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #1;
    check("rst_addr", wr_address, 0);
    check("rst_data", wr_data, 0);
    check("rst_wren", wr_en, 0);
    check("rst_cpurst", cpu_reset, 1);
    check("rst_done", done, 0);
    check("rst_err", error, 0);

    // Two-word frame, gapped bytes
    do_reset();
    fq = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    seal();
    send_gapped(0, fq.size() - 2);
    check("t1_done_early", done, 0);
    check("t1_cpurst_early", cpu_reset, 1);
    send_byte(fq[fq.size() - 1]);
    check("t1_done", done, 1);
    check("t1_cpurst", cpu_reset, 0);
    check("t1_nwr", wa_q.size(), 2);
    if (wa_q.size() == 2) begin
      check("t1_a0", wa_q[0], 0);
      check("t1_d0", wd_q[0], 16'h1234);
      check("t1_a1", wa_q[1], 1);
      check("t1_d1", wd_q[1], 16'hABCD);
    end
    fq = '{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22};
    send_gapped(0, 4);
    check("t1_ignored_nwr", wa_q.size(), 2);
    check("t1_still_done", done, 1);

    // Leading junk ignored
    do_reset();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    check("t2_junk_nwr", wa_q.size(), 0);
    check("t2_junk_err", error, 0);
    fq = '{8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF};
    seal();
    send_gapped(0, fq.size() - 1);
    check("t2_done", done, 1);
    check("t2_nwr", wa_q.size(), 1);
    if (wa_q.size() == 1) begin
      check("t2_a0", wa_q[0], 0);
      check("t2_d0", wd_q[0], 16'hBEEF);
    end

    // Oversize length, then restart from ERROR
    do_reset();
    send_byte(8'hA5); send_byte(8'h10);
    check("t3_err_early", error, 0);
    send_byte(8'h01);
    check("t3_err", error, 1);
    check("t3_cpurst", cpu_reset, 1);
    check("t3_nwr", wa_q.size(), 0);
    fq = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h07};
    seal();
    send_byte(fq[0]);
    check("t3_err_clr", error, 0);
    send_gapped(1, fq.size() - 1);
    check("t3_done", done, 1);
    check("t3_cpurst_lo", cpu_reset, 0);
    check("t3_nwr2", wa_q.size(), 1);
    if (wa_q.size() == 1) begin
      check("t3_a0", wa_q[0], 0);
      check("t3_d0", wd_q[0], 16'h0007);
    end

`ifdef LOADER_CHECKSUM_EN
    do_reset();
    fq = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
    send_gapped(0, 5);
    check("t4_done", done, 1);
    check("t4_err", error, 0);
    do_reset();
    fq = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h28};
    send_gapped(0, 5);
    check("t4_bad_err", error, 1);
    check("t4_bad_done", done, 0);
    check("t4_bad_cpurst", cpu_reset, 1);
    check("t4_bad_nwr", wa_q.size(), 1);
    if (wa_q.size() == 1) check("t4_bad_d0", wd_q[0], 16'h1234);
`endif

    // Asynchronous reset mid-frame, then a fresh frame from address 0
    do_reset();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    check("t5_pre_data", wr_data, 16'h1234);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("t5_async_data", wr_data, 0);
    check("t5_async_addr", wr_address, 0);
    check("t5_async_wren", wr_en, 0);
    check("t5_async_cpurst", cpu_reset, 1);
    check("t5_async_done", done, 0);
    check("t5_async_err", error, 0);
    @(negedge clock);
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    reset = 1'b0;
    fq = '{8'hA5, 8'h00, 8'h02, 8'hCA, 8'hFE, 8'h00, 8'h11};
    seal();
    send_gapped(0, fq.size() - 1);
    check("t5_done", done, 1);
    check("t5_nwr", wa_q.size(), 2);
    if (wa_q.size() == 2) begin
      check("t5_a0", wa_q[0], 0);
      check("t5_d0", wd_q[0], 16'hCAFE);
      check("t5_a1", wa_q[1], 1);
      check("t5_d1", wd_q[1], 16'h0011);
    end

    // Full-rate stream
    do_reset();
    fq = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    seal();
    stream(0);
    check("t6_done", done, 1);
    check("t6_nwr", wa_q.size(), 3);
    if (wa_q.size() == 3) begin
      check("t6_a0", wa_q[0], 0);
      check("t6_d0", wd_q[0], 16'h1122);
      check("t6_a1", wa_q[1], 1);
      check("t6_d1", wd_q[1], 16'h3344);
      check("t6_a2", wa_q[2], 2);
      check("t6_d2", wd_q[2], 16'h5566);
      check("t6_gap01", wc_q[1] - wc_q[0], 2);
      check("t6_gap12", wc_q[2] - wc_q[1], 2);
    end

    // Zero-length image
    do_reset();
    fq = '{8'hA5, 8'h00, 8'h00};
    seal();
    send_gapped(0, fq.size() - 1);
    check("t7_done", done, 1);
    check("t7_nwr", wa_q.size(), 0);

    // Image exactly filling memory
    do_reset();
    fq = '{8'hA5, 8'h10, 8'h00};
    for (int w = 0; w < 'h1000; w++) begin
      fq.push_back(8'(w >> 8));
      fq.push_back(8'(w));
    end
    seal();
    stream(0);
    check("t8_done", done, 1);
    check("t8_err", error, 0);
    check("t8_nwr", wa_q.size(), 'h1000);
    if (wa_q.size() == 'h1000) begin
      check("t8_a_last", wa_q[4095], 12'hFFF);
      check("t8_d_last", wd_q[4095], 16'h0FFF);
      check("t8_a_mid", wa_q[2048], 12'h800);
      check("t8_d_mid", wd_q[2048], 16'h0800);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
